// File: rtl/hazard_scoreboard_unit.sv
// Load-use hazard detector with multi-cycle bubble insertion and memory-busy freeze.
// Optional saturating bubble counter (StallCnt_o) is built when HAZARD_STATS_EN is defined.
module hazard_scoreboard_unit #(
    parameter int ADDR_W  = 5,
    parameter int MEM_LAT = 1,
    parameter int CNT_W   = 3
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              MemRead_i,
    input  logic [ADDR_W-1:0] RDaddr_i,
    input  logic [ADDR_W-1:0] RS1addr_i,
    input  logic [ADDR_W-1:0] RS2addr_i,
    input  logic              RS1Use_i,
    input  logic              RS2Use_i,
    input  logic              MemBusy_i,
    output logic              PCWrite_o,
    output logic              Stall_o,
    output logic              NoOp_o,
    output logic              Freeze_o,
    output logic              Busy_o
`ifdef HAZARD_STATS_EN
    ,
    output logic [31:0]       StallCnt_o
`endif
);

    typedef enum logic {
        IDLE  = 1'b0,
        STALL = 1'b1
    } state_t;

    localparam logic [CNT_W-1:0] LAT_M1    = CNT_W'(MEM_LAT - 1);
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(1);
    localparam bit               MULTI_CYC = (MEM_LAT > 1);

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic             hazard;
    logic             stall_req;
    logic             stall_act;

    // x0 is hard-wired zero and unused source fields carry garbage, so neither may match.
    assign hazard = MemRead_i && (RDaddr_i != '0) &&
                    ((RS1Use_i && (RS1addr_i == RDaddr_i)) ||
                     (RS2Use_i && (RS2addr_i == RDaddr_i)));

    always_comb begin
        // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latch).
        state_nxt = state;
        cnt_nxt   = cnt;
        stall_req = 1'b0;
        case (state)
            IDLE: begin
                stall_req = hazard;
                if (MULTI_CYC && hazard && !MemBusy_i) begin
                    state_nxt = STALL;
                    cnt_nxt   = LAT_M1;
                end
            end
            STALL: begin
                // ID/EX already holds a bubble, so the hazard compare is meaningless here.
                stall_req = 1'b1;
                if (!MemBusy_i) begin
                    cnt_nxt = cnt - 1'b1;
                    if (cnt == CNT_LAST) begin
                        state_nxt = IDLE;
                    end
                end
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // NOTE: rst_i also gates the combinational outputs, so a hazard on the inputs cannot leak through during reset.
    assign stall_act = rst_i && stall_req;
    assign PCWrite_o = !stall_act;
    assign Stall_o   = stall_act;
    assign NoOp_o    = stall_act;
    assign Freeze_o  = rst_i && MemBusy_i;
    assign Busy_o    = (state == STALL);

`ifdef HAZARD_STATS_EN
    logic [31:0] stall_cnt;

    // Counts bubbles that actually advance down the pipe; frozen cycles repeat the same bubble.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            stall_cnt <= '0;
        end else if (NoOp_o && !MemBusy_i && (stall_cnt != 32'hFFFF_FFFF)) begin
            stall_cnt <= stall_cnt + 32'd1;
        end
    end

    assign StallCnt_o = stall_cnt;
`endif

endmodule

// File: doc/hazard_scoreboard_unit.md
# hazard_scoreboard_unit

Parametrised load-use hazard detector for the in-order pipeline's ID stage, replacing the single-bubble detector. It compares the decode-stage source registers against a load sitting in ID/EX. On a match it holds PC and IF/ID and injects bubbles for a configurable number of cycles, so the data memory can take more than one cycle. It also freezes the whole pipeline while data memory reports busy, and can keep a saturating stall-cycle count.

## Interface
- ADDR_W, 5, register-address width
- MEM_LAT, 1, bubbles inserted per load-use hazard; legal range 1..(2^CNT_W − 1)
- CNT_W, 3, width of internal bubble counter
- clk_i  input  1  clock, rising edge
- rst_i  input  1  reset, asynchronous, active-low
- MemRead_i  input  1  ID/EX instruction is a load
- RDaddr_i  input  ADDR_W  ID/EX destination register
- RS1addr_i  input  ADDR_W  IF/ID source register 1
- RS2addr_i  input  ADDR_W  IF/ID source register 2
- RS1Use_i  input  1  IF/ID instruction reads RS1
- RS2Use_i  input  1  IF/ID instruction reads RS2
- MemBusy_i  input  1  data memory not ready; pipeline must hold
- PCWrite_o  output  1  PC may update
- Stall_o  output  1  hold IF/ID
- NoOp_o  output  1  replace ID/EX control with bubble
- Freeze_o  output  1  hold all pipeline registers
- Busy_o  output  1  state is STALL
- StallCnt_o  output  32  total bubble cycles issued; present only with HAZARD_STATS_EN

## Operation
- hazard = MemRead_i & (RDaddr_i != 0) & ((RS1Use_i & RS1addr_i == RDaddr_i) | (RS2Use_i & RS2addr_i == RDaddr_i)).
- Register x0 never causes a hazard. An unused source field never causes a hazard.
- States: IDLE, STALL. The bubble counter cnt is CNT_W bits.
- IDLE:
  - Stall outputs (PCWrite_o=0, Stall_o=1, NoOp_o=1) equal hazard, combinationally.
  - On hazard & !MemBusy_i with MEM_LAT>1: go to STALL and set cnt=MEM_LAT−1.
  - With MEM_LAT=1 the unit stays in IDLE. This gives single-bubble behaviour.
- STALL:
  - Stall outputs are asserted unconditionally. Hazard inputs are ignored, because ID/EX holds a bubble.
  - Each cycle with !MemBusy_i, cnt decrements. When cnt==1 at the clock edge, go to IDLE.
- Freeze_o = MemBusy_i, combinationally.
  - While MemBusy_i=1, state and cnt hold, and no transition occurs.
  - Stall outputs keep their normal values during a freeze.
- Busy_o = (state==STALL).
- Total bubbles per hazard = MEM_LAT, counting only non-frozen cycles.

## Timing
- Detection latency: 0 cycles (combinational). State and cnt are registered on the rising edge of clk_i.
- While rst_i=0, regardless of inputs:
  - state=IDLE, cnt=0.
  - PCWrite_o=1, Stall_o=0, NoOp_o=0, Freeze_o=0, Busy_o=0, StallCnt_o=0.
- Reset asserted mid-stall: the unit returns to IDLE immediately, with no residual bubbles after release.
- Hazard and MemBusy_i in the same cycle: Freeze_o=1 and stall outputs are asserted. The IDLE→STALL transition is deferred to the first non-busy cycle.
- Back-to-back hazards: a new hazard can be detected in the first IDLE cycle after STALL exits.

## Configuration
- HAZARD_STATS_EN defined:
  - Port StallCnt_o and a 32-bit register exist.
  - The register increments on every rising edge where NoOp_o=1 and MemBusy_i=0.
  - It saturates at 32'hFFFF_FFFF and clears on reset.
- HAZARD_STATS_EN undefined: the port and register are absent. All other behaviour is identical.

## Test plan
- Reset, then MemRead_i=1, RDaddr_i=5, RS1addr_i=5, RS1Use_i=1, MEM_LAT=1 -> PCWrite_o=0, Stall_o=1, NoOp_o=1 for exactly 1 cycle; Busy_o stays 0.
- Same hazard on RS2, MEM_LAT=3, MemRead_i dropped after the first cycle -> stall outputs high for exactly 3 consecutive cycles; Busy_o high in cycles 2–3; IDLE on cycle 4.
- RDaddr_i=0 = RS1addr_i with MemRead_i=1; or RS1 match with RS1Use_i=0 -> no stall, PCWrite_o=1.
- MEM_LAT=3 hazard, MemBusy_i=1 for 2 cycles in the middle of STALL -> Freeze_o=1 for those 2 cycles; stall outputs high for 5 cycles total; exactly 3 counted bubbles.
- rst_i pulsed low during the 2nd bubble of a MEM_LAT=4 stall -> outputs return to reset values immediately; no stall after release.
- HAZARD_STATS_EN: two MEM_LAT=3 hazards -> StallCnt_o=6. Preload the counter to 32'hFFFF_FFFE and apply one hazard -> StallCnt_o=32'hFFFF_FFFF and holds.
